// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the M-stage data-memory access path: access size,
// controller state and byte-strobe type, plus the alignment rule.
package mem_access_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef logic [3:0] strobe_t;

    function automatic logic addr_misaligned(msize_t size, logic [1:0] offset);
        return ((size == MSIZE2) && offset[0]) ||
               ((size == MSIZE4) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational byte-lane logic: store strobes, store data replication and
// load data extraction with optional sign extension.
module mem_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]        offset,
    input  msize_t            size,
    input  logic              store,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output strobe_t           strobe,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[7:0];
        case (offset)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        strobe    = '0;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            MSIZE1: begin
                if (store) strobe = strobe_t'(4'b0001) << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            MSIZE2: begin
                if (store) strobe = strobe_t'(4'b0011) << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            default: begin
                if (store) strobe = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: issues one bus request per load or
// store, stalls the pipeline until the response and returns the aligned load.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  msize_t            SizeM,
    input  logic              SignedM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              adv,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output msize_t            dreq_size,
    output strobe_t           dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              adel,
    output logic              ades
);

    mem_state_t        state, state_next;
    logic              discard, discard_next;
    logic              misaligned, op_valid, in_flight, load_fire, capture;
    logic [DATA_W-1:0] load_q;

    logic [ADDR_W-1:0] hold_addr, cur_addr;
    msize_t            hold_size, cur_size;
    logic              hold_signed, cur_signed;
    logic              hold_store, cur_store;
    logic [DATA_W-1:0] hold_wdata, cur_wdata;

    strobe_t           align_strobe;
    logic [DATA_W-1:0] align_wdata, align_rdata;

    assign misaligned = addr_misaligned(SizeM, ALUOutM[1:0]);
    assign op_valid   = (MemtoRegM | MemWriteM) & ~flush & ~misaligned;
    assign in_flight  = (state == ADDR) || (state == DATA);

    // Once a request leaves IDLE its attributes come from these registers, so
    // a flush or a changing M stage cannot disturb the pending bus request.
    always_ff @(posedge clk) begin
        if (state == IDLE && op_valid) begin
            hold_addr   <= ALUOutM;
            hold_size   <= SizeM;
            hold_signed <= SignedM;
            hold_store  <= MemWriteM;
            hold_wdata  <= WriteDataM;
        end
    end

    always_comb begin
        cur_addr   = hold_addr;
        cur_size   = hold_size;
        cur_signed = hold_signed;
        cur_store  = hold_store;
        cur_wdata  = hold_wdata;
        if (state == IDLE) begin
            cur_addr   = ALUOutM;
            cur_size   = SizeM;
            cur_signed = SignedM;
            cur_store  = MemWriteM;
            cur_wdata  = WriteDataM;
        end
    end

    mem_align u_align (
        .offset    (cur_addr[1:0]),
        .size      (cur_size),
        .store     (cur_store),
        .sign_ext  (cur_signed),
        .wdata     (cur_wdata),
        .rdata     (rdata),
        .strobe    (align_strobe),
        .wdata_rep (align_wdata),
        .rdata_ext (align_rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (addr_ok && data_ok) state_next = DONE;
                    else if (addr_ok)       state_next = DATA;
                    else                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (addr_ok && data_ok) state_next = (discard || flush) ? IDLE : DONE;
                else if (addr_ok)       state_next = DATA;
            end
            DATA: begin
                if (data_ok) state_next = (discard || flush) ? IDLE : DONE;
            end
            default: begin
                if (adv || flush) state_next = IDLE;
            end
        endcase
    end

    // A squashed access still runs to completion on the bus; the flag only
    // lives while the transaction is outstanding.
    assign discard_next = in_flight && (discard || flush) &&
                          ((state_next == ADDR) || (state_next == DATA));

    assign load_fire = data_ok && ((state == IDLE && op_valid && addr_ok) ||
                                   (state == ADDR && addr_ok) ||
                                   (state == DATA));
    assign capture   = load_fire && !cur_store && !discard && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            discard <= 1'b0;
            load_q  <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (capture) load_q <= align_rdata;
        end
    end

    assign dreq_valid  = resetn && ((state == IDLE && op_valid) || state == ADDR);
    assign dreq_addr   = cur_addr;
    assign dreq_size   = cur_size;
    assign dreq_strobe = align_strobe;
    assign dreq_data   = align_wdata;

    assign busy = resetn && ((state == IDLE && op_valid && !(addr_ok && data_ok)) ||
                             in_flight);
    assign adel = resetn && MemtoRegM && misaligned;
    assign ades = resetn && MemWriteM && misaligned;
    assign ReadDataM = !resetn ? '0 : (load_fire ? align_rdata : load_q);

endmodule
